// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the two-requester ALU arbiter.
//   - ALU op codes (ADD/SUB/AND are the documented ones; OR/XOR are extras)
//   - 2-bit state encodings for the arbiter FSM and the matching enum type
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_EXEC = ST_EXEC,
      S_RESP = ST_RESP
   } state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU.
// Ports:
//   a, b    in  WIDTH  operands
//   op      in  3      operation (ADD, SUB, AND, OR, XOR; others give 0)
//   result  out WIDTH  operation result
//   zero    out 1      result is all zeros
//   carry   out 1      carry-out for ADD, borrow for SUB, 0 otherwise
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry
);

   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_diff;

   assign w_sum  = {1'b0, a} + {1'b0, b};
   // MSB of the widened difference is set exactly when a < b (borrow)
   assign w_diff = {1'b0, a} - {1'b0, b};

   always_comb begin
      result = '0;
      carry  = 1'b0;
      case (op)
         OP_ADD:  {carry, result} = w_sum;
         OP_SUB:  {carry, result} = w_diff;
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         default: ;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// Each requester uses a valid/ready handshake; results come back on one
// registered response channel (rsp_valid/rsp_ready) tagged with rsp_id.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   reqN_valid/ready/a/b/op       requester N (N = 0,1) handshake + operation
//   rsp_valid/ready               response handshake
//   rsp_id/result/zero/carry      registered response fields
//   busy                          FSM is not in IDLE
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a request; grants one and latches its operands
// EXEC   | ALU evaluates latched operands; response registers load
// RESP   | response presented; held until rsp_ready
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [2:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [2:0]       req1_op,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   output logic             rsp_carry,
   output logic             busy
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_last_grant;
   logic             r_cur_id;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [2:0]       r_op;
   logic             r_rsp_id;
   logic [WIDTH-1:0] r_rsp_result;
   logic             r_rsp_zero;
   logic             r_rsp_carry;

   logic             w_any_valid;
   logic             w_grant_id;
   logic             w_accept;
   logic [WIDTH-1:0] w_alu_result;
   logic             w_alu_zero;
   logic             w_alu_carry;

   // Requester 1 wins if it is alone, or if both are valid and requester 0
   // had the previous grant.
   assign w_any_valid = req0_valid | req1_valid;
   assign w_grant_id  = req1_valid & (~req0_valid | ~r_last_grant);
   assign w_accept    = (r_state == S_IDLE) & w_any_valid & ~rst;

   always_comb begin
      w_state_nxt = r_state;
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      case (r_state)
         S_IDLE: begin
            // Masked during reset: a request seen while rst is high is not
            // latched, so it must not look accepted to the requester.
            if (w_accept) begin
               req0_ready  = ~w_grant_id;
               req1_ready  = w_grant_id;
               w_state_nxt = S_EXEC;
            end
         end
         S_EXEC:  w_state_nxt = S_RESP;
         S_RESP: begin
            if (rsp_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_last_grant <= 1'b1;
         r_cur_id     <= 1'b0;
         r_a          <= '0;
         r_b          <= '0;
         r_op         <= '0;
         r_rsp_id     <= 1'b0;
         r_rsp_result <= '0;
         r_rsp_zero   <= 1'b0;
         r_rsp_carry  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_a          <= w_grant_id ? req1_a  : req0_a;
            r_b          <= w_grant_id ? req1_b  : req0_b;
            r_op         <= w_grant_id ? req1_op : req0_op;
            r_cur_id     <= w_grant_id;
            r_last_grant <= w_grant_id;
         end
         if (r_state == S_EXEC) begin
            r_rsp_id     <= r_cur_id;
            r_rsp_result <= w_alu_result;
            r_rsp_zero   <= w_alu_zero;
            r_rsp_carry  <= w_alu_carry;
         end
      end
   end

   // ALU sees only the latched operands, so requesters may change their
   // inputs as soon as they are accepted.
   alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .a      (r_a),
      .b      (r_b),
      .op     (r_op),
      .result (w_alu_result),
      .zero   (w_alu_zero),
      .carry  (w_alu_carry)
   );

   assign rsp_valid  = (r_state == S_RESP);
   assign busy       = (r_state != S_IDLE);
   assign rsp_id     = r_rsp_id;
   assign rsp_result = r_rsp_result;
   assign rsp_zero   = r_rsp_zero;
   assign rsp_carry  = r_rsp_carry;

endmodule
